// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU engine that borrows the core ALU one op per cycle.
// Ports: clk, rst_n, start/op/a/b in; busy/done/hi/lo/div_by_zero out; alu_* to/from the core ALU.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ADD,
    DIV_CMP,
    DIV_SUB,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;
  logic             ge_r;

  logic             accept;
  logic             last;
  logic             carry;
  logic             ge;
  logic [WIDTH-1:0] sh;

  assign busy    = (state == MUL_ADD) ||
                   (state == DIV_CMP) ||
                   (state == DIV_SUB);
  assign done    = (state == DONE);
  assign alu_req = busy;

  assign accept = start & ~busy & ~op[1];
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign carry  = (alu_out < hi);
  assign sh     = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // A bit shifted out of hi means the partial remainder already exceeds dvsr.
  assign ge     = hi[WIDTH-1] | ~alu_out[0];

  always_comb begin
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = 4'b0000;
    unique case (state)
      MUL_ADD: begin
        alu_in1     = hi;
        alu_in2     = lo[0] ? opnd : '0;
        alu_control = ALU_ADD;
      end
      DIV_CMP: begin
        alu_in1     = sh;
        alu_in2     = opnd;
        alu_control = ALU_SLT;
      end
      DIV_SUB: begin
        alu_in1     = hi;
        alu_in2     = opnd;
        alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      ge_r        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      div_by_zero <= 1'b0;
      opnd        <= b;
      hi          <= '0;
      lo          <= a;
      if (!op[0]) begin
        state <= MUL_ADD;
      end else if (b == '0) begin
        hi          <= a;
        lo          <= '1;
        div_by_zero <= 1'b1;
        state       <= DONE;
      end else begin
        state <= DIV_CMP;
      end
    end else begin
      unique case (state)
        MUL_ADD: begin
          // Shift the 65-bit {carry,sum,lo} right by one.
          hi    <= {carry, alu_out[WIDTH-1:1]};
          lo    <= {alu_out[0], lo[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          state <= last ? DONE : MUL_ADD;
        end
        DIV_CMP: begin
          hi    <= sh;
          lo    <= {lo[WIDTH-2:0], ge};
          ge_r  <= ge;
          state <= DIV_SUB;
        end
        DIV_SUB: begin
          // Taken even when ge_r=0 so latency is data independent.
          if (ge_r) hi <= alu_out;
          cnt   <= cnt + CNT_W'(1);
          state <= last ? DONE : DIV_CMP;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer.
// Provides a behavioural ALU and an arithmetic reference for MULTU/DIVU.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero, alu_req;
  logic [31:0] hi, lo, alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_control;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_req(alu_req), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_control(alu_control), .alu_out(alu_out)
  );

  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = {31'b0, alu_in1 < alu_in2};
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    logic [63:0] p;
    if (o == 2'b00) begin
      p = {32'b0, x} * {32'b0, y};
      return p;
    end
    if (y == 0) return {x, 32'hFFFFFFFF};
    return {x % y, x / y};
  endfunction

  function automatic int ref_latency(input logic [1:0] o,
                                     input logic [31:0] y);
    if (o == 2'b00) return 33;
    if (y == 0) return 1;
    return 65;
  endfunction

  // Issues one op; lat counts edges from the accept edge to the first done
  // cycle. rp>0 re-pulses a DIVU start while busy at that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int rp,
                        output int lat, output int reqc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1; reqc = 0;
    while (!done && lat < 200) begin
      if (alu_req) reqc++;
      start = (lat == rp);
      op = 2'b01;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int rp);
    int lat, reqc;
    logic [63:0] exp;
    exp = ref_result(o, x, y);
    run_op(o, x, y, rp, lat, reqc);
    check({tag, ".lat"}, 64'(lat), 64'(ref_latency(o, y)));
    check({tag, ".hilo"}, {hi, lo}, exp);
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(o == 2'b01 && y == 0));
    check({tag, ".req"}, 64'(reqc), 64'(ref_latency(o, y) - 1));
    check({tag, ".idle_alu"}, {alu_in1, alu_in2, 28'b0, alu_control}, 0);
  endtask

  initial begin
    logic [63:0] held;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #12;
    check("reset.outs", {busy, done, div_by_zero, alu_req, alu_control},
          0);
    check("reset.hilo", {hi, lo}, 0);
    check("reset.alu", {alu_in1, alu_in2}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 0);
    do_op("mulmax", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op("div100_7", 2'b01, 32'd100, 32'd7, 0);
    do_op("divbig", 2'b01, 32'hFFFFFFFF, 32'h80000001, 0);
    do_op("divby1", 2'b01, 32'hFFFFFFFF, 32'd1, 0);
    do_op("divby0", 2'b01, 32'd5, 32'd0, 0);
    do_op("repulse", 2'b00, 32'h12345678, 32'h9ABCDEF0, 10);

    // Illegal op from idle leaves everything untouched.
    @(posedge clk); #1;
    held = {hi, lo};
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      start = 1'b1; op = 2'(k); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      check("illegal.busy", {62'b0, busy, done}, 0);
      check("illegal.hilo", {hi, lo}, held);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) @(posedge clk);
      do_op("rand", ro, ra, rb, 0);
    end

    // Async reset in the middle of a DIVU aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    check("abort.busy_pre", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort.outs", {busy, done, div_by_zero, alu_req, alu_control},
          0);
    check("abort.hilo", {hi, lo}, 0);
    check("abort.alu", {alu_in1, alu_in2}, 0);
    @(posedge clk); #1;
    check("abort.nodone", 64'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 2'b00, 32'd3, 32'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
